// File: rtl/shreg_pkg.sv
// -----------------------------------------------------------------------------
// shreg_pkg
// Shared definitions for the universal shift register:
//   - 3-bit operation codes (OP_NOP .. OP_CLR)
//   - controller state encoding
//   - shreg_op_is_shift(): true for the single-bit-step operations
//   - shreg_step(): next value of the register after one single-bit step
//
// shreg_step works on a SHREG_MAX_W-bit container so one function serves
// every register width up to SHREG_MAX_W. The live width is passed in.
// Bits above the live width are returned as zero.
// -----------------------------------------------------------------------------
package shreg_pkg;

    localparam int unsigned SHREG_MAX_W = 64;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_SHR  = 3'd3;
    localparam logic [2:0] OP_ASR  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_ROR  = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shreg_state_e;

    function automatic logic shreg_op_is_shift(input logic [2:0] op);
        return (op >= OP_SHL) && (op <= OP_ROR);
    endfunction

    function automatic logic [SHREG_MAX_W-1:0] shreg_step(
        input logic [SHREG_MAX_W-1:0] q,
        input logic [2:0]             op,
        input logic                   sin_l,
        input logic                   sin_r,
        input int unsigned            width = SHREG_MAX_W
    );
        logic [SHREG_MAX_W-1:0] one;
        logic [SHREG_MAX_W-1:0] top;
        logic [SHREG_MAX_W-1:0] mask;
        logic [SHREG_MAX_W-1:0] r;
        logic                   msb;
        one  = {{(SHREG_MAX_W-1){1'b0}}, 1'b1};
        // 'top' is the live MSB position; 'mask' keeps only the live bits.
        top  = one << (width - 1);
        mask = ~({SHREG_MAX_W{1'b1}} << width);
        msb  = |(q & top);
        case (op)
            OP_SHL:  r = (q << 1) | (sin_r ? one : '0);
            OP_SHR:  r = (q >> 1) | (sin_l ? top : '0);
            OP_ASR:  r = (q >> 1) | (msb   ? top : '0);
            OP_ROL:  r = (q << 1) | (msb   ? one : '0);
            OP_ROR:  r = (q >> 1) | (q[0]  ? top : '0);
            default: r = q;
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/shreg_ctl.sv
// -----------------------------------------------------------------------------
// shreg_ctl
// Command controller for univ_shift_reg: IDLE/SHIFT FSM, remaining-step
// counter and busy/done generation. It tells the datapath which operation
// to apply at the coming edge through exec_op (OP_NOP means hold).
//
// Ports:
//   clk1      in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   cmd_valid in   command present
//   cmd_op    in   operation code
//   cmd_amt   in   number of single-bit steps for shift ops
//   cmd_ready out  command can be accepted (= !busy)
//   busy      out  multi-step shift in progress
//   done      out  registered one-cycle completion pulse
//   exec_op   out  operation the datapath performs at the next edge
// -----------------------------------------------------------------------------
module shreg_ctl
    import shreg_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          cmd_valid,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_amt,
    output logic          cmd_ready,
    output logic          busy,
    output logic          done,
    output logic [2:0]    exec_op
);

    shreg_state_e  state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;
    logic          done_q, done_d;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NOP;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            done_q  <= done_d;
        end
    end

    // NOTE: every output of this block is given a default first so no path
    // leaves a variable unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        done_d  = 1'b0;
        exec_op = OP_NOP;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (shreg_op_is_shift(cmd_op)) begin
                        if (cmd_amt == '0) begin
                            // Zero-step shift completes like a NOP.
                            done_d = 1'b1;
                        end else begin
                            // First step happens at the acceptance edge.
                            exec_op = cmd_op;
                            if (cmd_amt >= AW'(2)) begin
                                state_d = ST_SHIFT;
                                cnt_d   = cmd_amt - AW'(1);
                                op_d    = cmd_op;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                    end else begin
                        exec_op = cmd_op;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                // Latched op only; cmd_* inputs are ignored here.
                exec_op = op_q;
                cnt_d   = cnt_q - AW'(1);
                if (cnt_q == AW'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q == ST_SHIFT);
    assign cmd_ready = !busy;
    assign done      = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
// Parametrised universal shift register with a command handshake. Supports
// load, clear, shift left/right, arithmetic shift right and rotates, with
// an N-step auto-shift driven by shreg_ctl.
//
// Parameters:
//   WIDTH  register width (2 .. SHREG_MAX_W)
//   AW     width of the shift-amount field
// Ports:
//   clk1       in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted (= !busy)
//   cmd_op     in   operation code (see shreg_pkg)
//   cmd_amt    in   number of single-bit steps for shift ops
//   load_data  in   parallel load value
//   sin_r      in   serial input into bit 0 (SHL), sampled each step
//   sin_l      in   serial input into bit WIDTH-1 (SHR), sampled each step
//   q          out  register contents
//   sout_msb   out  q[WIDTH-1]
//   sout_lsb   out  q[0]
//   busy       out  multi-step shift in progress
//   done       out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module univ_shift_reg
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_amt,
    input  logic [WIDTH-1:0] load_data,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [2:0]       exec_op;

    shreg_ctl #(.AW(AW)) u_ctl (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .done      (done),
        .exec_op   (exec_op)
    );

    always_comb begin
        q_d = q_q;
        case (exec_op)
            OP_NOP:  q_d = q_q;
            OP_LOAD: q_d = load_data;
            OP_CLR:  q_d = '0;
            default: q_d = WIDTH'(shreg_step(SHREG_MAX_W'(q_q), exec_op,
                                             sin_l, sin_r, WIDTH));
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q        = q_q;
    assign sout_msb = q_q[WIDTH-1];
    assign sout_lsb = q_q[0];

endmodule
